// File: rtl/lib_pkg.sv
// Shared FIFO library: ceiling-log2 helper and the status bundle reused by
// every FIFO flavour in this codebase.
package lib_pkg;

    localparam int unsigned STAT_LVL_W = 32'd16;

    typedef struct packed {
        logic [STAT_LVL_W-1:0] level;
        logic                  full;
        logic                  empty;
        logic                  almost_full;
        logic                  almost_empty;
    } fifo_status_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 32'd0;
        rem = value - 32'd1;
        while (rem != 32'd0) begin
            rem = rem >> 1;
            res = res + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ring_fifo_rdy_ack_if.sv
// Producer/consumer rdy/ack bundle plus status for ring_fifo_rdy_ack.
// slave is the FIFO side, master is the environment side.
interface ring_fifo_rdy_ack_if #(
    parameter int unsigned DW    = 32'd8,
    parameter int unsigned DEPTH = 32'd8
);
    localparam int unsigned AW = lib_pkg::clog2(DEPTH);

    logic          i_rdy;
    logic          i_ack;
    logic [DW-1:0] i_data;
    logic          o_rdy;
    logic          o_ack;
    logic [DW-1:0] o_data;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;

    modport slave (
        input  i_rdy, i_data, o_ack,
        output i_ack, o_rdy, o_data, level, full, empty, almost_full, almost_empty
    );

    modport master (
        output i_rdy, i_data, o_ack,
        input  i_ack, o_rdy, o_data, level, full, empty, almost_full, almost_empty
    );

endinterface

// File: rtl/fifo_ram_1w1r.sv
// Simple dual-port storage: one clocked write port, one asynchronous read port.
// Deliberately unreset; the pointers decide which entries are meaningful.
module fifo_ram_1w1r #(
    parameter  int unsigned DW    = 32'd8,
    parameter  int unsigned DEPTH = 32'd8,
    localparam int unsigned AW    = lib_pkg::clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ring_fifo_rdy_ack.sv
// Pointer-addressed ring FIFO with a registered output stage, optional
// empty-path bypass, synchronous flush and registered status.
module ring_fifo_rdy_ack
    import lib_pkg::*;
#(
    parameter int unsigned DW     = 32'd8,
    parameter int unsigned DEPTH  = 32'd8,
    parameter int unsigned AF_TH  = DEPTH - 32'd1,
    parameter int unsigned AE_TH  = 32'd1,
    parameter int unsigned BYPASS = 32'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    ring_fifo_rdy_ack_if.slave bus
);

    localparam int unsigned           AW       = clog2(DEPTH);
    localparam bit                    BYP_EN   = (BYPASS != 32'd0);
    localparam logic [STAT_LVL_W-1:0] AF_L     = STAT_LVL_W'(AF_TH);
    localparam logic [STAT_LVL_W-1:0] AE_L     = STAT_LVL_W'(AE_TH);
    localparam logic [AW:0]           PTR_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]           PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]           PTR_ZERO = {(AW+1){1'b0}};

    logic [AW:0]           wr_ptr_r, rd_ptr_r;
    logic [AW:0]           wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [AW:0]           ram_cnt_s, ram_cnt_nxt_s;
    logic                  o_rdy_r, o_rdy_nxt_s;
    logic [DW-1:0]         o_data_r, o_data_nxt_s;
    logic [DW-1:0]         ram_rdata_s;
    logic [STAT_LVL_W-1:0] level_nxt_s;
    fifo_status_t          status_r, status_nxt_s;
    logic                  i_ack_s, push_s, ld_s, pop_s, byp_s, wr_en_s, ram_empty_s;
    logic                  unused_level_s;

    fifo_ram_1w1r #(
        .DW   (DW),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en_s),
        .waddr(wr_ptr_r[AW-1:0]),
        .wdata(bus.i_data),
        .raddr(rd_ptr_r[AW-1:0]),
        .rdata(ram_rdata_s)
    );

    // i_ack comes only from the registered full flag and the flush pin
    assign i_ack_s = ~status_r.full & ~flush;

    // Handshake decode: push, output-stage load, RAM pop and bypass
    always_comb begin
        ram_cnt_s   = wr_ptr_r - rd_ptr_r;
        ram_empty_s = (ram_cnt_s == PTR_ZERO);
        push_s      = bus.i_rdy & i_ack_s;
        ld_s        = ~o_rdy_r | bus.o_ack;
        pop_s       = ~ram_empty_s & ld_s & ~flush;
        byp_s       = BYP_EN & push_s & ram_empty_s & ld_s;
        wr_en_s     = push_s & ~byp_s;
    end

    // Next pointers and output stage; a reload takes priority over o_ack clearing
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        o_rdy_nxt_s  = o_rdy_r;
        o_data_nxt_s = o_data_r;
        if (flush) begin
            wr_ptr_nxt_s = PTR_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
            o_rdy_nxt_s  = 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                o_rdy_nxt_s  = 1'b1;
                o_data_nxt_s = ram_rdata_s;
            end else if (byp_s) begin
                o_rdy_nxt_s  = 1'b1;
                o_data_nxt_s = bus.i_data;
            end else if (bus.o_ack) begin
                o_rdy_nxt_s  = 1'b0;
            end else begin
                o_rdy_nxt_s  = o_rdy_r;
            end
        end
    end

    // Status derived from next-state values so it lines up with o_rdy and pointers
    always_comb begin
        ram_cnt_nxt_s             = wr_ptr_nxt_s - rd_ptr_nxt_s;
        level_nxt_s               = STAT_LVL_W'(ram_cnt_nxt_s) + STAT_LVL_W'(o_rdy_nxt_s);
        status_nxt_s.level        = level_nxt_s;
        status_nxt_s.full         = ((wr_ptr_nxt_s ^ rd_ptr_nxt_s) == PTR_FULL);
        status_nxt_s.empty        = (level_nxt_s == {STAT_LVL_W{1'b0}});
        status_nxt_s.almost_full  = (level_nxt_s >= AF_L);
        status_nxt_s.almost_empty = (level_nxt_s <= AE_L);
    end

    // State registers; asynchronous reset drops any in-flight word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r              <= PTR_ZERO;
            rd_ptr_r              <= PTR_ZERO;
            o_rdy_r               <= 1'b0;
            o_data_r              <= {DW{1'b0}};
            status_r.level        <= {STAT_LVL_W{1'b0}};
            status_r.full         <= 1'b0;
            status_r.empty        <= 1'b1;
            status_r.almost_full  <= (AF_L == {STAT_LVL_W{1'b0}});
            status_r.almost_empty <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            o_rdy_r  <= o_rdy_nxt_s;
            o_data_r <= o_data_nxt_s;
            status_r <= status_nxt_s;
        end
    end

    assign bus.i_ack        = i_ack_s;
    assign bus.o_rdy        = o_rdy_r;
    assign bus.o_data       = o_data_r;
    assign bus.level        = status_r.level[AW:0];
    assign bus.full         = status_r.full;
    assign bus.empty        = status_r.empty;
    assign bus.almost_full  = status_r.almost_full;
    assign bus.almost_empty = status_r.almost_empty;
    assign unused_level_s   = ^status_r.level[STAT_LVL_W-1:AW+1];

endmodule

// File: doc/ring_fifo_rdy_ack.md
# ring_fifo_rdy_ack

Single-clock, parametrised ring-buffer FIFO with rdy/ack handshakes on both sides, a registered output stage, optional write-to-output bypass, synchronous flush, and registered level/threshold status. It is the general-purpose successor to the shift-register FIFO. It replaces the data shifting with pointer-addressed storage, so depth scales without per-write shifting of every entry. It sits between any rdy/ack producer and consumer inside one clock domain.

## Interface
- DW, 8, data width in bits
- DEPTH, 8, RAM entries; power of 2, ≥2; AW = clog2(DEPTH), derived, not overridable
- AF_TH, DEPTH-1, almost_full asserted when level ≥ AF_TH
- AE_TH, 1, almost_empty asserted when level ≤ AE_TH
- BYPASS, 0, 1 = a write may load the output stage directly when the RAM is empty
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all contents
- i_rdy  in  1  producer has valid i_data
- i_ack  out  1  FIFO accepts; i_ack = !full & !flush (combinational from registered full)
- i_data  in  DW  write data
- o_rdy  out  1  o_data valid (output-stage occupied)
- o_ack  in  1  consumer accepts
- o_data  out  DW  output-stage data, registered
- level  out  AW+1  occupancy = RAM entries + o_rdy, range 0..DEPTH+1
- full  out  1  RAM holds DEPTH entries
- empty  out  1  level == 0
- almost_full  out  1  level ≥ AF_TH
- almost_empty  out  1  level ≤ AE_TH

## Operation
- Push: i_rdy & i_ack. Accepted data is written to RAM[wr_ptr[AW-1:0]] and wr_ptr increments, unless the bypass rule below applies.
- Pointers wr_ptr and rd_ptr are AW+1 bits. RAM count = wr_ptr - rd_ptr, modulo 2^(AW+1). full when the pointers differ only in the MSB. Wrap past DEPTH-1 is natural.
- Load condition: ld = (!o_rdy | o_ack).
- Pop: RAM non-empty & ld. o_data ← RAM[rd_ptr[AW-1:0]], rd_ptr increments, o_rdy ← 1.
- Bypass (BYPASS=1 only): push & RAM empty & ld. o_data ← i_data, o_rdy ← 1, and neither pointer moves.
- o_ack with no reload: o_rdy ← 0, o_data holds its value.
- Simultaneous push and pop: both happen, so the RAM count is unchanged. A push into a full RAM is impossible because i_ack is low, even if a pop occurs in the same cycle.
- Flush: in the next cycle both pointers are 0, o_rdy is 0 and status returns to reset values. A push in the flush cycle is blocked because i_ack is low. o_ack is ignored during flush.
- Status outputs (level, full, empty, almost_*) are registered from next-state values, so they are consistent with o_rdy and the pointers on the same cycle.
- The RAM contents are not reset.

## Timing
- Reset values: o_rdy 0, o_data 0, level 0, full 0, empty 1, almost_full 0 (unless AF_TH = 0), almost_empty 1, i_ack 1 when flush = 0.
- Latency, BYPASS=0, empty FIFO: push at cycle N → o_rdy high at N+2.
- Latency, BYPASS=1, empty FIFO: push at cycle N → o_rdy high at N+1.
- Throughput: 1 push and 1 pop per cycle, sustained.
- Occupancy: maximum is DEPTH+1 words. full (and i_ack low) begins the cycle after the DEPTH-th word lands in the RAM.
- Asynchronous reset mid-transfer: all state clears immediately and the in-flight word is dropped.

## Structure
- Shared package lib_pkg holds:
  - the clog2 function;
  - the status struct {level, full, empty, almost_full, almost_empty} for reuse by later FIFOs.
- Sub-module fifo_ram_1w1r(DW, DEPTH): one write port clocked on clk, one combinational read port. It has no reset.
- Top level holds the pointers, output stage, bypass mux, flush logic and status registers.

## Test plan
- DEPTH=4, BYPASS=0, o_ack=0, push 0x10..0x15 on consecutive cycles → 0x10–0x14 accepted, i_ack low for 0x15, level=5, full=1, almost_full=1.
- Drain that state with o_ack=1 every cycle → o_data sequence 0x10..0x14, then o_rdy=0, empty=1, pointers wrapped.
- BYPASS=1, empty FIFO, single push of 0xA5 at cycle N → o_rdy=1 and o_data=0xA5 at N+1, level=1.
- BYPASS=0, same single push → o_rdy rises at N+2.
- Continuous push and pop with random data for 200 cycles, including wrap past DEPTH-1 → output matches the scoreboard in order and level stays constant at steady state.
- Flush asserted with level=3 while i_rdy=1 → i_ack=0 that cycle; next cycle level=0, o_rdy=0, empty=1.
- Async reset pulse with level=4 → all outputs at reset values within the same cycle; the first subsequent push is delivered correctly.
